product_bcd_display: RTL and testbench
======================================

// Module: product_bcd_display
// PURPOSE
//  Downstream stage of the 8x8 shift-add multiplier. It consumes the 16-bit product and its done pulse.
//  Converts the product to 5 BCD digits with a sequential double-dabble, one shift per cycle.
//  Holds the result in a display register and time-multiplexes it onto an 8-position 7-segment display.
//  The display updates only on conversion completion, so it never flickers mid-conversion.
// PARAMETERS
//  DATA_W    16    binary input width; the shift counter runs DATA_W cycles
//  DIGITS    5     BCD digits produced; must hold 2^DATA_W-1
//  POSITIONS 8     display positions scanned; positions >= DIGITS are always blank
//  SCAN_DIV  1000  clk cycles each position stays lit; minimum 1
// PORTS
//  clk        in   1         system clock, rising edge
//  rst        in   1         synchronous, active-high reset
//  load       in   1         1-cycle pulse (multiplier done_flag); samples d_in
//  d_in       in   DATA_W    binary product to convert
//  busy       out  1         conversion in progress
//  bcd_valid  out  1         bcd holds a completed result; level
//  bcd        out  4*DIGITS  last result, digit 0 = bcd[3:0] (least significant)
//  seg        out  8         active-low segments, seg[7]=dp (always 1), seg[6:0]=g..a
//  an         out  8         active-low position enables, one-hot-zero or all ones
// BEHAVIOUR
//  Reset (any state, any cycle): FSM=IDLE, busy=0, bcd_valid=0, bcd=0, display reg=0.
//   Also clears scan counter and position index; an=8'hFE, seg=8'hC0 ('0').
//  FSM has three states: IDLE, SHIFT, DONE.
//  IDLE: if load=1 at edge k:
//   - capture d_in into the binary shift reg, clear the BCD shift reg, cnt=0
//   - clear bcd_valid, busy<=1, go to SHIFT.
//  SHIFT: on each edge, every BCD nibble >=5 gets +3 first.
//   - then {bcd_sr,bin_sr} shifts left 1 and cnt increments.
//   - after DATA_W shifts (edge k+DATA_W), go to DONE.
//  DONE (edge k+DATA_W+1): bcd<=bcd_sr, display reg<=bcd_sr, bcd_valid<=1, busy<=0, go to IDLE.
//  Latency: load edge to bcd_valid high = DATA_W+1 = 17 cycles. Next load accepted the cycle after.
//  load while busy (SHIFT or DONE) is ignored entirely; there is no queueing.
//  bcd and bcd_valid hold until the next accepted load or rst.
//  Arithmetic: add-3 is nibble-local; no nibble can exceed 9 after the final shift for DATA_W=16, DIGITS=5.
//  Scan: scan_cnt counts 0..SCAN_DIV-1. On wrap, pos increments mod POSITIONS. an/seg are registered.
//   - an[pos]=0 only if position pos is lit; otherwise an=8'hFF.
//  Leading-zero blanking: position p>0 is lit only if some display digit at index >=p is nonzero.
//   - position 0 is always lit, showing '0' for zero.
//  Blank positions drive seg=8'hFF. Digit codes are active-low 0..9:
//   - 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99
//   - 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90
//  Scan runs continuously, independent of the FSM. rst mid-scan restarts at position 0.
// STRUCTURE
//  Shared package/header (prod_disp_pkg): DATA_W, DIGITS, POSITIONS defaults, FSM state encodings.
//   - It also holds the SEG_* active-low digit constants and SEG_BLANK=8'hFF.
//  Sub-module bcd_to_seg7: combinational nibble->seg decode; a non-BCD input maps to SEG_BLANK.
//  Top of block: FSM + datapath (double-dabble) and scan counter + blanking + output registers.
// TESTING (SCAN_DIV=4 for scan tests)
//  1 rst held 2 cycles -> busy=0, bcd_valid=0, bcd=0, an=FE, seg=C0; rst mid-SHIFT -> all cleared next cycle, new load converts correctly.
//  2 load with d_in=16'd255 -> busy=1 for 17 cycles, bcd=20'h00255 and bcd_valid=1 17 cycles after load.
//  3 d_in=16'hFFFF -> bcd=20'h65535. Scan shows positions 0..4 in turn, 4 cycles each:
//    - an = FE,FD,FB,F7,EF; seg = 92,B0,92,92,82
//    - then an=FF for 3 positions, then the sequence wraps to FE
//  4 load d_in=1234 then load d_in=9 at cycle +5 -> second load ignored; bcd=20'h01234, display unchanged until first done.
//  5 d_in=0 -> bcd=0; only position 0 lit with C0. d_in=1200 -> positions 0..3 lit (0,0,2,1), position 4 blank.
//  6 back-to-back: load on the cycle right after bcd_valid rises -> accepted, bcd_valid drops, new result 17 cycles later.

Source files
------------

// File: rtl/product_bcd_display_pkg.sv
// Shared definitions for the product BCD display block.
// Holds default sizing parameters, FSM state encodings, the active-low 7-segment
// digit codes and the nibble add-3 helper used by the double-dabble converter.
package product_bcd_display_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_DIGITS    = 5;
  localparam int DEF_POSITIONS = 8;
  localparam int DEF_SCAN_DIV  = 1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Active-low segment codes, bit 7 is the decimal point (kept dark).
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9
  // after the next shift, so pre-add 3 to carry it into the next digit.
  function automatic logic [3:0] add3_nibble(input logic [3:0] n);
    if (n >= 4'd5) begin
      return n + 4'd3;
    end else begin
      return n;
    end
  endfunction

endpackage

// File: rtl/product_bcd_display_if.sv
// Bus bundle between the multiplier side (master) and the BCD display block (slave).
//   load/d_in : product handoff from the multiplier
//   busy/bcd_valid/bcd : conversion status and result
//   seg/an : active-low 7-segment drive
interface product_bcd_display_if
  import product_bcd_display_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DIGITS    = DEF_DIGITS,
  parameter int POSITIONS = DEF_POSITIONS
) ();

  logic                   load;
  logic [DATA_W-1:0]      d_in;
  logic                   busy;
  logic                   bcd_valid;
  logic [4*DIGITS-1:0]    bcd;
  logic [7:0]             seg;
  logic [POSITIONS-1:0]   an;

  modport master (
    output load, d_in,
    input  busy, bcd_valid, bcd, seg, an
  );

  modport slave (
    input  load, d_in,
    output busy, bcd_valid, bcd, seg, an
  );

endinterface

// File: rtl/product_bcd_display_bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder.
//   nibble_i : BCD digit 0..9 (10..15 decode to blank)
//   seg_o    : {dp, g..a}, active low, dp always off
module product_bcd_display_bcd_to_seg7
  import product_bcd_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  // Digit lookup; non-BCD codes blank the position rather than show garbage.
  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/product_bcd_display.sv
// Converts a binary product to BCD with a one-shift-per-cycle double-dabble and
// scans the latched result onto a multiplexed 7-segment display.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of product_bcd_display_if (load/d_in in; busy,
//              bcd_valid, bcd, seg, an out)
module product_bcd_display
  import product_bcd_display_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DIGITS    = DEF_DIGITS,
  parameter int POSITIONS = DEF_POSITIONS,
  parameter int SCAN_DIV  = DEF_SCAN_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  product_bcd_display_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int POS_W = $clog2(POSITIONS);
  localparam int SC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BCD_W = 4 * DIGITS;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0]     bcd_sr_q, bcd_sr_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [BCD_W-1:0]     disp_q, disp_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [BCD_W-1:0]     adj_s;

  logic [SC_W-1:0]      scan_cnt_q, scan_cnt_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [POSITIONS-1:0] an_q, an_d;
  logic [7:0]           seg_q, seg_d;
  logic [POSITIONS-1:0] lit_s;
  logic                 any_nz_s;
  logic [4*POSITIONS-1:0] disp_pad_s;
  logic [3:0]           digit_s;
  logic [7:0]           dec_s;

  // Per-nibble add-3 correction applied before every shift.
  always_comb begin
    adj_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj_s[4*i +: 4] = add3_nibble(bcd_sr_q[4*i +: 4]);
    end
  end

  // FSM next state and converter datapath.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bin_sr_d = bin_sr_q;
    bcd_sr_d = bcd_sr_q;
    bcd_d    = bcd_q;
    disp_d   = disp_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          bin_sr_d = bus.d_in;
          bcd_sr_d = '0;
          cnt_d    = '0;
          valid_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_SHIFT;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        {bcd_sr_d, bin_sr_d} = {adj_s[BCD_W-2:0], bin_sr_q, 1'b0};
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        bcd_d   = bcd_sr_q;
        disp_d  = bcd_sr_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and converter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bin_sr_q <= '0;
      bcd_sr_q <= '0;
      bcd_q    <= '0;
      disp_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bin_sr_q <= bin_sr_d;
      bcd_sr_q <= bcd_sr_d;
      bcd_q    <= bcd_d;
      disp_q   <= disp_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  // Leading-zero blanking: a position is lit if it or any higher digit is
  // nonzero; position 0 is always lit so zero shows as '0'.
  always_comb begin
    lit_s    = '0;
    any_nz_s = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz_s = any_nz_s | (disp_q[4*i +: 4] != 4'd0);
      lit_s[i] = any_nz_s | (i == 0);
    end
  end

  // Select the digit for the current position; positions past DIGITS read zero
  // but are never lit.
  always_comb begin
    disp_pad_s = '0;
    disp_pad_s[BCD_W-1:0] = disp_q;
    digit_s = disp_pad_s[{pos_q, 2'b00} +: 4];
  end

  product_bcd_display_bcd_to_seg7 u_dec (
    .nibble_i (digit_s),
    .seg_o    (dec_s)
  );

  // Scan counter, position advance and next display drive.
  always_comb begin
    scan_cnt_d = scan_cnt_q + {{(SC_W-1){1'b0}}, 1'b1};
    pos_d      = pos_q;
    if (scan_cnt_q == SC_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      if (pos_q == POS_W'(POSITIONS - 1)) begin
        pos_d = '0;
      end else begin
        pos_d = pos_q + {{(POS_W-1){1'b0}}, 1'b1};
      end
    end else begin
      pos_d = pos_q;
    end
    an_d  = '1;
    seg_d = SEG_BLANK;
    if (lit_s[pos_q]) begin
      an_d[pos_q] = 1'b0;
      seg_d       = dec_s;
    end else begin
      an_d  = '1;
      seg_d = SEG_BLANK;
    end
  end

  // Scan state and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      pos_q      <= '0;
      an_q       <= {{(POSITIONS-1){1'b1}}, 1'b0};
      seg_q      <= SEG_0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      pos_q      <= pos_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.bcd_valid = valid_q;
  assign bus.bcd       = bcd_q;
  assign bus.seg       = seg_q;
  assign bus.an        = an_q;

endmodule

// File: tb/tb_product_bcd_display.sv
// Directed testbench for product_bcd_display with a short scan period.
module tb_product_bcd_display;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  product_bcd_display_if bus_if ();

  product_bcd_display #(.SCAN_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Pulse load for one cycle; returns 1ns after the sampling edge.
  task automatic pulse_load(input logic [15:0] v);
    @(posedge clk); #1;
    bus_if.load = 1'b1;
    bus_if.d_in = v;
    @(posedge clk); #1;
    bus_if.load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.load = 1'b0;
    bus_if.d_in = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if ({bus_if.busy, bus_if.bcd_valid} !== 2'b00) begin
      errors++; $display("FAIL rst_flags got %b want 00", {bus_if.busy, bus_if.bcd_valid});
    end
    vectors++;
    if (bus_if.bcd !== 20'h00000) begin
      errors++; $display("FAIL rst_bcd got %h want 00000", bus_if.bcd);
    end
    vectors++;
    if ({bus_if.an, bus_if.seg} !== 16'hFEC0) begin
      errors++; $display("FAIL rst_disp got an=%h seg=%h want FE C0", bus_if.an, bus_if.seg);
    end
    // reset in the middle of a conversion
    pulse_load(16'd500);
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    vectors++;
    if ({bus_if.busy, bus_if.bcd_valid, bus_if.bcd, bus_if.an, bus_if.seg} !== {2'b00, 20'h00000, 16'hFEC0}) begin
      errors++; $display("FAIL rst_mid got busy=%b v=%b bcd=%h an=%h seg=%h want 0 0 00000 FE C0",
                         bus_if.busy, bus_if.bcd_valid, bus_if.bcd, bus_if.an, bus_if.seg);
    end
    pulse_load(16'd4321);
    repeat (17) @(posedge clk);
    #1;
    vectors++;
    if ({bus_if.bcd_valid, bus_if.bcd} !== {1'b1, 20'h04321}) begin
      errors++; $display("FAIL rst_reload got v=%b bcd=%h want 1 04321", bus_if.bcd_valid, bus_if.bcd);
    end
  endtask

  task automatic test_latency();
    int bad = 0;
    pulse_load(16'd255);
    vectors++;
    if ({bus_if.busy, bus_if.bcd_valid} !== 2'b10) begin
      errors++; $display("FAIL lat_start got busy=%b v=%b want 1 0", bus_if.busy, bus_if.bcd_valid);
    end
    for (int j = 1; j <= 16; j++) begin
      @(posedge clk); #1;
      if ({bus_if.busy, bus_if.bcd_valid} !== 2'b10) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++; $display("FAIL lat_busy got %0d bad cycles want 0", bad);
    end
    @(posedge clk); #1;
    vectors++;
    if ({bus_if.busy, bus_if.bcd_valid, bus_if.bcd} !== {2'b01, 20'h00255}) begin
      errors++; $display("FAIL lat_done got busy=%b v=%b bcd=%h want 0 1 00255",
                         bus_if.busy, bus_if.bcd_valid, bus_if.bcd);
    end
  endtask

  task automatic test_max();
    pulse_load(16'hFFFF);
    repeat (17) @(posedge clk);
    #1;
    vectors++;
    if ({bus_if.bcd_valid, bus_if.bcd} !== {1'b1, 20'h65535}) begin
      errors++; $display("FAIL max got v=%b bcd=%h want 1 65535", bus_if.bcd_valid, bus_if.bcd);
    end
  endtask

  task automatic test_overlap();
    pulse_load(16'd1234);
    repeat (4) @(posedge clk);
    #1;
    bus_if.load = 1'b1;
    bus_if.d_in = 16'd9;
    @(posedge clk); #1;
    bus_if.load = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    vectors++;
    if ({bus_if.busy, bus_if.bcd_valid, bus_if.bcd} !== {2'b10, 20'h65535}) begin
      errors++; $display("FAIL ovl_hold got busy=%b v=%b bcd=%h want 1 0 65535",
                         bus_if.busy, bus_if.bcd_valid, bus_if.bcd);
    end
    @(posedge clk); #1;
    vectors++;
    if ({bus_if.bcd_valid, bus_if.bcd} !== {1'b1, 20'h01234}) begin
      errors++; $display("FAIL ovl_done got v=%b bcd=%h want 1 01234", bus_if.bcd_valid, bus_if.bcd);
    end
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if ({bus_if.busy, bus_if.bcd_valid, bus_if.bcd} !== {2'b01, 20'h01234}) begin
      errors++; $display("FAIL ovl_noqueue got busy=%b v=%b bcd=%h want 0 1 01234",
                         bus_if.busy, bus_if.bcd_valid, bus_if.bcd);
    end
  endtask

  task automatic test_back_to_back();
    pulse_load(16'd9999);
    repeat (17) @(posedge clk);
    #1;
    vectors++;
    if ({bus_if.bcd_valid, bus_if.bcd} !== {1'b1, 20'h09999}) begin
      errors++; $display("FAIL b2b_first got v=%b bcd=%h want 1 09999", bus_if.bcd_valid, bus_if.bcd);
    end
    bus_if.load = 1'b1;
    bus_if.d_in = 16'd42;
    @(posedge clk); #1;
    bus_if.load = 1'b0;
    vectors++;
    if ({bus_if.busy, bus_if.bcd_valid} !== 2'b10) begin
      errors++; $display("FAIL b2b_accept got busy=%b v=%b want 1 0", bus_if.busy, bus_if.bcd_valid);
    end
    repeat (16) @(posedge clk);
    #1;
    vectors++;
    if (bus_if.bcd_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_early got v=%b want 0", bus_if.bcd_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if ({bus_if.bcd_valid, bus_if.bcd} !== {1'b1, 20'h00042}) begin
      errors++; $display("FAIL b2b_second got v=%b bcd=%h want 1 00042", bus_if.bcd_valid, bus_if.bcd);
    end
  endtask

  task automatic test_scan();
    logic [15:0] val_t [3];
    logic [63:0] an_t  [3];
    logic [63:0] seg_t [3];
    logic [7:0]  an_log  [72];
    logic [7:0]  seg_log [72];
    // expected per position p at bits [8*p +: 8]
    val_t[0] = 16'hFFFF;
    an_t[0]  = 64'hFFFF_FFEF_F7FB_FDFE;
    seg_t[0] = 64'hFFFF_FF82_9292_B092;
    val_t[1] = 16'd0;
    an_t[1]  = 64'hFFFF_FFFF_FFFF_FFFE;
    seg_t[1] = 64'hFFFF_FFFF_FFFF_FFC0;
    val_t[2] = 16'd1200;
    an_t[2]  = 64'hFFFF_FFFF_F7FB_FDFE;
    seg_t[2] = 64'hFFFF_FFFF_F9A4_C0C0;
    for (int t = 0; t < 3; t++) begin
      int start = -1;
      pulse_load(val_t[t]);
      repeat (18) @(posedge clk);
      for (int k = 0; k < 72; k++) begin
        @(negedge clk);
        an_log[k]  = bus_if.an;
        seg_log[k] = bus_if.seg;
      end
      for (int k = 1; k < 32; k++) begin
        if (start < 0 && an_log[k] == 8'hFE && an_log[k-1] != 8'hFE) start = k;
      end
      vectors++;
      if (start < 0) begin
        errors++; $display("FAIL scan_sync case %0d got no an=FE entry want one", t);
      end else begin
        for (int p = 0; p < 8; p++) begin
          logic [7:0] ea;
          logic [7:0] es;
          int bad = 0;
          ea = an_t[t][8*p +: 8];
          es = seg_t[t][8*p +: 8];
          for (int c = 0; c < 4; c++) begin
            if (an_log[start + 4*p + c] !== ea || seg_log[start + 4*p + c] !== es) bad++;
          end
          vectors++;
          if (bad != 0) begin
            errors++; $display("FAIL scan case %0d pos %0d got an=%h seg=%h want an=%h seg=%h",
                               t, p, an_log[start + 4*p], seg_log[start + 4*p], ea, es);
          end
        end
        vectors++;
        if (an_log[start + 32] !== 8'hFE) begin
          errors++; $display("FAIL scan_wrap case %0d got an=%h want FE", t, an_log[start + 32]);
        end
      end
    end
  endtask

  initial begin
    bus_if.load = 1'b0;
    bus_if.d_in = 16'd0;
    test_reset();
    test_latency();
    test_max();
    test_overlap();
    test_back_to_back();
    test_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
